// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: arbitrates LSU wait, control-flow redirect and
// load-use hazards into the stall/bubble controls of regF..regW.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal flow; redirect and load-use hazards are detected here
// LSU_WAIT | memory stage waiting on the LSU; F/D/E/M held, W bubbled
// FLUSH    | post-redirect IFU shadow; regD bubbled until flush_cnt hits 0
module pipe_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int LSU_TIMEOUT  = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  decode_i_rs1,
   input  logic [4:0]  decode_i_rs2,
   input  logic        decode_i_use_rs1,
   input  logic        decode_i_use_rs2,
   input  logic [4:0]  regE_i_wb_rd,
   input  logic        regE_i_is_load,
   input  logic        ex_i_redirect,
   input  logic        mem_i_req,
   input  logic        mem_i_done,
   output logic        ctrl_o_regF_stall,
   output logic        ctrl_o_regD_stall,
   output logic        ctrl_o_regD_bubble,
   output logic        ctrl_o_regE_stall,
   output logic        ctrl_o_regE_bubble,
   output logic        ctrl_o_regM_stall,
   output logic        ctrl_o_regW_bubble,
   output logic [31:0] ctrl_o_stall_cnt,
   output logic        ctrl_o_lsu_timeout
);

   localparam int WAIT_W = $clog2(LSU_TIMEOUT) + 1;
   localparam logic [WAIT_W-1:0] WAIT_TC    = WAIT_W'(LSU_TIMEOUT);
   localparam logic [3:0]        FLUSH_INIT = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;
   localparam logic              HAS_FLUSH  = (FLUSH_CYCLES > 0);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LSU_WAIT = 2'd1,
      ST_FLUSH    = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        flush_cnt_q, flush_cnt_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [31:0]       stall_cnt_q, stall_cnt_d;
   logic              timeout_q, timeout_d;

   logic              rs1_hit, rs2_hit, load_use, lsu_stall, redirect;
   logic [WAIT_W-1:0] wait_inc;
   logic              f_stall, d_stall, d_bubble, e_stall, e_bubble, m_stall, w_bubble;

   always_comb begin
      rs1_hit   = decode_i_use_rs1 && (decode_i_rs1 == regE_i_wb_rd);
      rs2_hit   = decode_i_use_rs2 && (decode_i_rs2 == regE_i_wb_rd);
      load_use  = (state_q == ST_RUN) && regE_i_is_load && (regE_i_wb_rd != 5'd0)
                  && (rs1_hit || rs2_hit);
      // In LSU_WAIT only the done pulse releases; req may already have dropped.
      lsu_stall = (state_q == ST_LSU_WAIT) ? !mem_i_done : (mem_i_req && !mem_i_done);
      redirect  = !lsu_stall && ex_i_redirect;
      wait_inc  = (wait_cnt_q == WAIT_TC) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
   end

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      f_stall     = 1'b0;
      d_stall     = 1'b0;
      d_bubble    = 1'b0;
      e_stall     = 1'b0;
      e_bubble    = 1'b0;
      m_stall     = 1'b0;
      w_bubble    = 1'b0;

      if (lsu_stall) begin
         f_stall  = 1'b1;
         d_stall  = 1'b1;
         e_stall  = 1'b1;
         m_stall  = 1'b1;
         w_bubble = 1'b1;
         if (state_q == ST_LSU_WAIT) begin
            wait_cnt_d = wait_inc;
         end else begin
            state_d    = ST_LSU_WAIT;
            wait_cnt_d = '0;
         end
      end else begin
         if (state_q == ST_LSU_WAIT) begin
            state_d    = ST_RUN;
            wait_cnt_d = wait_inc;
         end
         if (redirect) begin
            d_bubble = 1'b1;
            e_bubble = 1'b1;
            if (HAS_FLUSH) begin
               state_d     = ST_FLUSH;
               flush_cnt_d = FLUSH_INIT;
            end else begin
               state_d = ST_RUN;
            end
         end else if (state_q == ST_FLUSH) begin
            d_bubble = 1'b1;
            if (flush_cnt_q == 4'd0) begin
               state_d = ST_RUN;
            end else begin
               flush_cnt_d = flush_cnt_q - 4'd1;
            end
         end else if (load_use) begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_bubble = 1'b1;
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q + {31'd0, f_stall};
      timeout_d   = timeout_q || ((state_q == ST_LSU_WAIT) && (wait_cnt_d == WAIT_TC));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         flush_cnt_q <= 4'd0;
         wait_cnt_q  <= '0;
         stall_cnt_q <= 32'd0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   // Reset forces NOPs into every bubbled register and releases every hold.
   always_comb begin
      ctrl_o_regF_stall  = !rst && f_stall;
      ctrl_o_regD_stall  = !rst && d_stall;
      ctrl_o_regD_bubble = rst  || d_bubble;
      ctrl_o_regE_stall  = !rst && e_stall;
      ctrl_o_regE_bubble = rst  || e_bubble;
      ctrl_o_regM_stall  = !rst && m_stall;
      ctrl_o_regW_bubble = rst  || w_bubble;
      ctrl_o_stall_cnt   = stall_cnt_q;
      ctrl_o_lsu_timeout = timeout_q;
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with FLUSH_CYCLES=2, LSU_TIMEOUT=8.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  decode_i_rs1, decode_i_rs2, regE_i_wb_rd;
   logic        decode_i_use_rs1, decode_i_use_rs2, regE_i_is_load;
   logic        ex_i_redirect, mem_i_req, mem_i_done;
   logic        f_stall, d_stall, d_bub, e_stall, e_bub, m_stall, w_bub;
   logic [31:0] stall_cnt;
   logic        lsu_timeout;

   int vectors = 0;
   int errors  = 0;

   // Output patterns packed as {F_stall, D_stall, D_bub, E_stall, E_bub, M_stall, W_bub}
   localparam logic [6:0] P_IDLE  = 7'b0000000;
   localparam logic [6:0] P_RST   = 7'b0010101;
   localparam logic [6:0] P_LOAD  = 7'b1100100;
   localparam logic [6:0] P_LSU   = 7'b1101011;
   localparam logic [6:0] P_REDIR = 7'b0010100;
   localparam logic [6:0] P_FLUSH = 7'b0010000;

   pipe_ctrl #(.FLUSH_CYCLES(2), .LSU_TIMEOUT(8)) dut (
      .clk                (clk),
      .rst                (rst),
      .decode_i_rs1       (decode_i_rs1),
      .decode_i_rs2       (decode_i_rs2),
      .decode_i_use_rs1   (decode_i_use_rs1),
      .decode_i_use_rs2   (decode_i_use_rs2),
      .regE_i_wb_rd       (regE_i_wb_rd),
      .regE_i_is_load     (regE_i_is_load),
      .ex_i_redirect      (ex_i_redirect),
      .mem_i_req          (mem_i_req),
      .mem_i_done         (mem_i_done),
      .ctrl_o_regF_stall  (f_stall),
      .ctrl_o_regD_stall  (d_stall),
      .ctrl_o_regD_bubble (d_bub),
      .ctrl_o_regE_stall  (e_stall),
      .ctrl_o_regE_bubble (e_bub),
      .ctrl_o_regM_stall  (m_stall),
      .ctrl_o_regW_bubble (w_bub),
      .ctrl_o_stall_cnt   (stall_cnt),
      .ctrl_o_lsu_timeout (lsu_timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_pat(input string tag, input logic [6:0] exp);
      logic [6:0] obs;
      #1;
      obs = {f_stall, d_stall, d_bub, e_stall, e_bub, m_stall, w_bub};
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: ctrl pattern observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input logic [31:0] exp);
      vectors++;
      assert (stall_cnt === exp) else begin
         errors++;
         $error("FAIL %s: stall_cnt observed=%0d expected=%0d", tag, stall_cnt, exp);
      end
   endtask

   task automatic chk_to(input string tag, input logic exp);
      vectors++;
      assert (lsu_timeout === exp) else begin
         errors++;
         $error("FAIL %s: lsu_timeout observed=%b expected=%b", tag, lsu_timeout, exp);
      end
   endtask

   task automatic clear_in();
      decode_i_rs1     = 5'd0;
      decode_i_rs2     = 5'd0;
      decode_i_use_rs1 = 1'b0;
      decode_i_use_rs2 = 1'b0;
      regE_i_wb_rd     = 5'd0;
      regE_i_is_load   = 1'b0;
      ex_i_redirect    = 1'b0;
      mem_i_req        = 1'b0;
      mem_i_done       = 1'b0;
   endtask

   initial begin
      clear_in();
      rst = 1'b1;
      chk_pat("reset_c0", P_RST);
      tick();
      chk_pat("reset_c1", P_RST);
      tick();
      rst = 1'b0;
      chk_pat("idle_after_reset", P_IDLE);
      chk_cnt("cnt_after_reset", 32'd0);
      chk_to("timeout_after_reset", 1'b0);

      // load-use on rs2
      regE_i_is_load = 1'b1; regE_i_wb_rd = 5'd5; decode_i_rs2 = 5'd5; decode_i_use_rs2 = 1'b1;
      chk_pat("load_use_rs2", P_LOAD);
      tick();
      regE_i_is_load = 1'b0;
      chk_pat("load_advanced", P_IDLE);
      chk_cnt("cnt_load_use", 32'd1);
      regE_i_is_load = 1'b1; regE_i_wb_rd = 5'd0; decode_i_rs2 = 5'd0;
      chk_pat("load_rd_x0", P_IDLE);
      tick();
      clear_in();
      regE_i_is_load = 1'b1; regE_i_wb_rd = 5'd7; decode_i_rs1 = 5'd7; decode_i_use_rs1 = 1'b1;
      chk_pat("load_use_rs1", P_LOAD);
      tick();
      decode_i_use_rs1 = 1'b0;
      chk_pat("rs1_unused_no_stall", P_IDLE);
      chk_cnt("cnt_load_use_rs1", 32'd2);
      tick();
      clear_in();

      // LSU store wait with a concurrent redirect, done four cycles later
      mem_i_req = 1'b1; ex_i_redirect = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk_pat($sformatf("lsu_wait_%0d", i), P_LSU);
         tick();
      end
      mem_i_done = 1'b1;
      chk_pat("lsu_release_redirect", P_REDIR);
      chk_cnt("cnt_lsu", 32'd6);
      tick();
      clear_in();
      chk_pat("flush_1", P_FLUSH);
      tick();
      chk_pat("flush_2", P_FLUSH);
      tick();
      chk_pat("flush_done", P_IDLE);
      tick();

      // second redirect inside FLUSH restarts the flush
      ex_i_redirect = 1'b1;
      chk_pat("redir_a", P_REDIR);
      tick();
      ex_i_redirect = 1'b0;
      chk_pat("redir_a_flush_1", P_FLUSH);
      tick();
      ex_i_redirect = 1'b1;
      chk_pat("redir_b_in_flush", P_REDIR);
      tick();
      ex_i_redirect = 1'b0;
      chk_pat("redir_b_flush_1", P_FLUSH);
      tick();
      chk_pat("redir_b_flush_2", P_FLUSH);
      tick();
      chk_pat("redir_b_done", P_IDLE);
      tick();

      // memory request during FLUSH takes over and drops the flush
      ex_i_redirect = 1'b1;
      chk_pat("redir_c", P_REDIR);
      tick();
      ex_i_redirect = 1'b0; mem_i_req = 1'b1;
      chk_pat("lsu_in_flush", P_LSU);
      tick();
      mem_i_req = 1'b0; mem_i_done = 1'b1;
      chk_pat("lsu_in_flush_release", P_IDLE);
      tick();
      mem_i_done = 1'b0;
      chk_pat("flush_dropped", P_IDLE);
      chk_cnt("cnt_flush_lsu", 32'd7);

      // priority: LSU beats redirect and load-use in the same cycle
      mem_i_req = 1'b1; ex_i_redirect = 1'b1;
      regE_i_is_load = 1'b1; regE_i_wb_rd = 5'd9; decode_i_rs1 = 5'd9; decode_i_use_rs1 = 1'b1;
      chk_pat("priority_lsu", P_LSU);
      tick();
      clear_in();
      mem_i_done = 1'b1;
      chk_pat("priority_release", P_IDLE);
      tick();
      mem_i_req = 1'b1;
      chk_pat("req_and_done_same_cycle", P_IDLE);
      tick();
      clear_in();
      chk_cnt("cnt_priority", 32'd8);

      // timeout after 8 LSU_WAIT cycles
      mem_i_req = 1'b1;
      chk_pat("to_entry", P_LSU);
      tick();
      chk_to("to_wait0", 1'b0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk_to($sformatf("to_wait%0d", k), (k == 8));
      end
      chk_pat("to_still_waiting", P_LSU);
      mem_i_req = 1'b0; mem_i_done = 1'b1;
      chk_pat("to_release", P_IDLE);
      chk_cnt("cnt_timeout", 32'd17);
      tick();
      mem_i_done = 1'b0;
      chk_to("to_sticky_1", 1'b1);
      tick();
      chk_to("to_sticky_2", 1'b1);

      // reset in the middle of LSU_WAIT
      mem_i_req = 1'b1;
      tick();
      rst = 1'b1;
      chk_pat("reset_mid_wait", P_RST);
      tick();
      rst = 1'b0; mem_i_req = 1'b0;
      chk_pat("after_mid_wait_reset", P_IDLE);
      chk_cnt("cnt_cleared", 32'd0);
      chk_to("timeout_cleared", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
